// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
// Holds the fetch PC, picks the next PC from the ID-stage PCSrc code, and
// registers {instruction, PC, PC+4} into ID. The kernel bit (PC[31]) is kept
// on sequential fetch and can only be cleared, never set, by jr/jalr.
// Optional build macro IF_PERF_CNT_EN adds FetchCount/BubbleCount outputs.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [25:0] JumpTarget,
    input  logic [31:0] JrTarget,
    input  logic        IF_Flush,
    input  logic        Stall,
    input  logic [31:0] Instruction_in,
    input  logic        InstReady,
    output logic [31:0] PC,
    output logic        PC_31,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id,
    output logic [31:0] PCPlus4_id,
    output logic        PC_id_31,
    output logic        Valid_id
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
`endif
);

    localparam logic [2:0] SRC_SEQ    = 3'b000;
    localparam logic [2:0] SRC_BRANCH = 3'b001;
    localparam logic [2:0] SRC_JUMP   = 3'b010;
    localparam logic [2:0] SRC_JR     = 3'b011;
    localparam logic [2:0] SRC_IRQ    = 3'b100;
    localparam logic [2:0] SRC_EXC    = 3'b101;

    logic [31:0] pc_seq;
    logic [31:0] pc_target;
    logic        redirect;
    logic        fetch_ok;

    // Target bits that the address formation never looks at.
    logic unused_bits;
    assign unused_bits = &{1'b0, BranchTarget[31], BranchTarget[1:0], JrTarget[1:0]};

    // Sequential increment stays inside the current half of the address space.
    assign pc_seq   = {PC[31], PC[30:0] + 31'd4};
    assign PC_31    = PC[31];
    assign PC_id_31 = PC_id[31];

    // A real fetch needs no stall, no redirect, no flush and valid memory data.
    assign fetch_ok = !Stall && !redirect && !IF_Flush && InstReady;

    // Decode PCSrc into a redirect flag and its target address; 11x falls back to sequential.
    always_comb begin
        redirect  = 1'b1;
        pc_target = pc_seq;
        case (PCSrc)
            SRC_BRANCH: pc_target = {PC_id[31], BranchTarget[30:2], 2'b00};
            SRC_JUMP:   pc_target = {PC_id[31], PCPlus4_id[30:28], JumpTarget, 2'b00};
            SRC_JR:     pc_target = {JrTarget[31] & PC_id[31], JrTarget[30:2], 2'b00};
            SRC_IRQ:    pc_target = IRQ_VEC;
            SRC_EXC:    pc_target = EXC_VEC;
            SRC_SEQ:    redirect  = 1'b0;
            default:    redirect  = 1'b0;
        endcase
    end

    // PC update and IF/ID register: stall holds everything, redirect/flush/no-data insert a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC             <= RESET_PC;
            Instruction_id <= 32'd0;
            PC_id          <= 32'd0;
            PCPlus4_id     <= 32'd0;
            Valid_id       <= 1'b0;
        end else if (!Stall) begin
            if (redirect) begin
                PC             <= pc_target;
                Instruction_id <= 32'd0;
                Valid_id       <= 1'b0;
            end else if (IF_Flush) begin
                if (InstReady) begin
                    PC <= pc_seq;
                end
                Instruction_id <= 32'd0;
                Valid_id       <= 1'b0;
            end else if (!InstReady) begin
                Instruction_id <= 32'd0;
                Valid_id       <= 1'b0;
            end else begin
                PC             <= pc_seq;
                Instruction_id <= Instruction_in;
                PC_id          <= PC;
                PCPlus4_id     <= pc_seq;
                Valid_id       <= 1'b1;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    // Count real fetches and inserted bubbles; both freeze while stalled and wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            FetchCount  <= 32'd0;
            BubbleCount <= 32'd0;
        end else if (!Stall) begin
            if (fetch_ok) begin
                FetchCount <= FetchCount + 32'd1;
            end else begin
                BubbleCount <= BubbleCount + 32'd1;
            end
        end
    end
`else
    logic unused_fetch;
    assign unused_fetch = fetch_ok;
`endif

endmodule
